// File: rtl/key_mode_ctrl.sv
// Single-button press classifier: short press advances the gear, long press toggles run/stop.
// Optional build macro KEY_AUTOREPEAT_EN: while running, holding past a long press repeats gear steps.
module key_mode_ctrl #(
  parameter int TICK_DIV   = 25,
  parameter int LONG_TICKS = 200,
  parameter int MAX_GEAR   = 3
) (
  input  logic       clk,
  input  logic       CR,
  input  logic       key_lvl,
  output logic       run,
  output logic [1:0] gear,
  output logic       short_press,
  output logic       long_press
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_LONG  = 2'd2;

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
  localparam logic [7:0] HOLD_LAST = 8'(LONG_TICKS - 1);
  localparam logic [1:0] GEAR_TOP  = 2'(MAX_GEAR);

  logic [1:0] state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic [7:0] hold_q, hold_d;
  logic       key_q;
  logic       run_q, run_d;
  logic [1:0] gear_q, gear_d;
  logic       short_q, short_d;
  logic       long_q, long_d;
  logic       press_edge;
  logic       release_edge;

  function automatic logic [1:0] gear_next(input logic [1:0] g);
    if (g == GEAR_TOP) begin
      return 2'd0;
    end else begin
      return g + 2'd1;
    end
  endfunction

  assign press_edge   = key_q & ~key_lvl;
  assign release_edge = ~key_q & key_lvl;

  // Next-state logic: hold timing, classification and mode updates
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    run_d   = run_q;
    gear_d  = gear_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_edge) begin
          state_d = S_PRESS;
          presc_d = 8'd0;
          hold_d  = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESS: begin
        // A release on the threshold edge is still a short press
        if (release_edge) begin
          short_d = 1'b1;
          gear_d  = gear_next(gear_q);
          state_d = S_IDLE;
        end else if (presc_q == TICK_LAST) begin
          presc_d = 8'd0;
          if (hold_q == HOLD_LAST) begin
            long_d  = 1'b1;
            run_d   = ~run_q;
            if (run_q) begin
              gear_d = 2'd0;
            end else begin
              gear_d = gear_q;
            end
            hold_d  = 8'd0;
            state_d = S_LONG;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      S_LONG: begin
        if (release_edge) begin
          state_d = S_IDLE;
        end else begin
`ifdef KEY_AUTOREPEAT_EN
          if (run_q) begin
            if (presc_q == TICK_LAST) begin
              presc_d = 8'd0;
              if (hold_q == HOLD_LAST) begin
                hold_d  = 8'd0;
                short_d = 1'b1;
                gear_d  = gear_next(gear_q);
              end else begin
                hold_d = hold_q + 8'd1;
              end
            end else begin
              presc_d = presc_q + 8'd1;
            end
          end else begin
            state_d = S_LONG;
          end
`else
          state_d = S_LONG;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = 8'd0;
        hold_d  = 8'd0;
      end
    endcase
  end

  // State and output registers; key_q tracks the key even during reset
  always_ff @(posedge clk) begin
    key_q <= key_lvl;
    if (CR) begin
      state_q <= S_IDLE;
      presc_q <= 8'd0;
      hold_q  <= 8'd0;
      run_q   <= 1'b0;
      gear_q  <= 2'd0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      run_q   <= run_d;
      gear_q  <= gear_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign run         = run_q;
  assign gear        = gear_q;
  assign short_press = short_q;
  assign long_press  = long_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Randomized bench for key_mode_ctrl against an edge-counting reference model.
module tb_key_mode_ctrl;

  localparam int TD  = 4;
  localparam int LT  = 5;
  localparam int MG  = 3;
  localparam int THR = TD * LT;

  logic       clk;
  logic       CR;
  logic       key_lvl;
  logic       run;
  logic [1:0] gear;
  logic       short_press;
  logic       long_press;

  int n_checks;
  int n_fail;

  // reference model state
  bit m_prev;
  bit m_in_press;
  bit m_long_done;
  int m_n;
  bit m_run;
  int m_gear;
  bit m_sp;
  bit m_lp;
  int short_cnt;
  int long_cnt;

  key_mode_ctrl #(.TICK_DIV(TD), .LONG_TICKS(LT), .MAX_GEAR(MG)) dut (
    .clk(clk), .CR(CR), .key_lvl(key_lvl), .run(run), .gear(gear),
    .short_press(short_press), .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gadv(input int g);
    return (g == MG) ? 0 : g + 1;
  endfunction

  // One clock: apply inputs, advance the model, compare after the edge
  task automatic step(input bit k, input bit cr);
    bit press, rel;
    key_lvl = k;
    CR      = cr;
    m_sp = 1'b0;
    m_lp = 1'b0;
    if (cr) begin
      m_in_press = 1'b0;
      m_run      = 1'b0;
      m_gear     = 0;
    end else begin
      press = m_prev && !k;
      rel   = !m_prev && k;
      if (!m_in_press) begin
        if (press) begin
          m_in_press  = 1'b1;
          m_long_done = 1'b0;
          m_n         = 0;
        end
      end else if (rel) begin
        if (!m_long_done) begin
          m_sp   = 1'b1;
          m_gear = gadv(m_gear);
        end
        m_in_press = 1'b0;
      end else begin
        m_n++;
        if (!m_long_done && m_n == THR) begin
          m_lp = 1'b1;
          if (m_run) m_gear = 0;
          m_run       = !m_run;
          m_long_done = 1'b1;
          m_n         = 0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (m_long_done && m_run && m_n == THR) begin
          m_sp   = 1'b1;
          m_gear = gadv(m_gear);
          m_n    = 0;
        end
`endif
      end
    end
    m_prev = k;
    @(posedge clk);
    #1;
    if (m_sp) short_cnt++;
    if (m_lp) long_cnt++;
    chk("run", int'(run), int'(m_run));
    chk("gear", int'(gear), m_gear);
    chk("short_press", int'(short_press), int'(m_sp));
    chk("long_press", int'(long_press), int'(m_lp));
  endtask

  task automatic press_for(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
  endtask

  initial begin
    int hold_len;
    int sc0, lc0;
    int picks [10] = '{1, 2, 3, 8, 19, 20, 21, 30, 45, 60};
    n_checks = 0;
    n_fail   = 0;
    short_cnt = 0;
    long_cnt  = 0;
    m_prev = 1'b1;
    m_n = 0;
    m_long_done = 1'b0;
    key_lvl = 1'b1;
    CR = 1'b1;

    // reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("rst_run", int'(run), 0);
    chk("rst_gear", int'(gear), 0);
    step(1'b1, 1'b0);

    // short press, then gear wrap
    press_for(8);
    chk("short_gear1", int'(gear), 1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      press_for(3);
      step(1'b1, 1'b0);
    end
    chk("wrap_gear0", int'(gear), 0);

    // long press starts run, no short on release
    sc0 = short_cnt;
    lc0 = long_cnt;
    press_for(30);
    chk("long_run", int'(run), 1);
    chk("long_cnt", long_cnt - lc0, 1);
    step(1'b1, 1'b0);

    // gear to 2, then long press stops and clears gear
    press_for(2); step(1'b1, 1'b0);
    press_for(2); step(1'b1, 1'b0);
    chk("gear2", int'(gear), 2);
    press_for(30);
    chk("stop_run", int'(run), 0);
    chk("stop_gear", int'(gear), 0);
    step(1'b1, 1'b0);

    // release on exactly the threshold edge: short wins
    lc0 = long_cnt;
    press_for(THR);
    chk("tie_no_long", long_cnt - lc0, 0);
    chk("tie_run", int'(run), 0);
    step(1'b1, 1'b0);

    // key held through reset, then held on: no press edge
    sc0 = short_cnt;
    lc0 = long_cnt;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("heldrst_pulses", (short_cnt - sc0) + (long_cnt - lc0), 0);
    step(1'b1, 1'b0);

    // reset mid-press, then a fresh full hold
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("midrst_pulses", (short_cnt - sc0) + (long_cnt - lc0), 0);
    press_for(60);
    step(1'b1, 1'b0);

    // randomized presses with occasional reset
    for (int p = 0; p < 150; p++) begin
      if ($urandom_range(0, 1) == 0) hold_len = picks[$urandom_range(0, 9)];
      else hold_len = $urandom_range(1, 70);
      for (int i = 0; i < hold_len; i++) begin
        if ($urandom_range(0, 199) == 0) step(1'b0, 1'b1);
        else step(1'b0, 1'b0);
      end
      step(1'b1, 1'b0);
      for (int g = $urandom_range(0, 3); g > 0; g--) step(1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
